// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 size codes,
// FSM state encoding, fault causes and the load lane-extraction helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } lsu_state_t;

    // Fault cause, already resolved by priority (illegal > misalign > range)
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_RANGE    = 2'b11
    } lsu_err_t;

    // Pick the addressed lane(s) out of a RAM word and extend to 32 bits
    function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                                input logic [31:0] word,
                                                input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = word;
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational request decode: size/sign legality, misalign and range
// checks, store byte-enable mask and lane-shifted store data, load extraction.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  is_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           wdata,
    input  logic [31:0]           ram_word,
    output logic [3:0]            byte_en,
    output logic [31:0]           wdata_shifted,
    output logic [31:0]           load_data,
    output logic                  error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic     legal_s;
    logic     size_half_s;
    logic     size_word_s;
    logic     misalign_s;
    logic     range_s;
    lsu_err_t err_kind_s;

    // Decode the access size and check the request for faults in priority order
    always_comb begin
        legal_s     = 1'b0;
        size_half_s = 1'b0;
        size_word_s = 1'b0;
        case (funct3)
            F3_B:    legal_s = 1'b1;
            F3_H:    begin legal_s = 1'b1; size_half_s = 1'b1; end
            F3_W:    begin legal_s = 1'b1; size_word_s = 1'b1; end
            F3_BU:   legal_s = ~is_write;
            F3_HU:   begin legal_s = ~is_write; size_half_s = 1'b1; end
            default: legal_s = 1'b0;
        endcase

        misalign_s = (size_half_s & address[0]) |
                     (size_word_s & (address[1:0] != 2'b00));
        range_s    = (address >> (IDX_W + 2)) != {ADDR_WIDTH{1'b0}};

        if (!legal_s) begin
            err_kind_s = ERR_ILLEGAL;
        end else if (misalign_s) begin
            err_kind_s = ERR_MISALIGN;
        end else if (range_s) begin
            err_kind_s = ERR_RANGE;
        end else begin
            err_kind_s = ERR_NONE;
        end
        error = (err_kind_s != ERR_NONE);
    end

    // Byte-lane write mask and lane-aligned store data; faults write nothing
    always_comb begin
        wdata_shifted = wdata << {address[1:0], 3'b000};
        if (error || !is_write) begin
            byte_en = 4'b0000;
        end else if (size_word_s) begin
            byte_en = 4'b1111;
        end else if (size_half_s) begin
            byte_en = 4'b0011 << address[1:0];
        end else begin
            byte_en = 4'b0001 << address[1:0];
        end
    end

    // Extended load result, forced to zero on any fault
    always_comb begin
        if (error) begin
            load_data = 32'h0000_0000;
        end else begin
            load_data = extend_load(funct3, ram_word, address[1:0]);
        end
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Data memory with RISC-V sub-word load/store, byte-masked writes, fault
// reporting and a valid/ready request/response handshake. One transaction
// is in flight at a time; loads return READ_LATENCY cycles after accept.
module data_memory_lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    // Contents survive reset_n; they start at zero only at time 0
    logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0000_0000};

    lsu_state_t       state_r;
    logic [2:0]       lat_cnt_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_error_r;

    logic [IDX_W-1:0] word_idx_s;
    logic [31:0]      ram_word_s;
    logic [3:0]       byte_en_s;
    logic [31:0]      wdata_shifted_s;
    logic [31:0]      load_data_s;
    logic             error_s;
    logic             accept_s;

    assign word_idx_s = req_address[IDX_W+1:2];
    assign ram_word_s = mem[word_idx_s];
    assign accept_s   = req_valid & req_ready_r & (state_r == IDLE);

    lsu_align #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_align (
        .is_write      (req_write),
        .funct3        (req_funct3),
        .address       (req_address),
        .wdata         (req_wdata),
        .ram_word      (ram_word_s),
        .byte_en       (byte_en_s),
        .wdata_shifted (wdata_shifted_s),
        .load_data     (load_data_s),
        .error         (error_s)
    );

    // Commit stores on the accept edge, one byte lane at a time
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (accept_s && byte_en_s[i]) begin
                mem[word_idx_s][8*i +: 8] <= wdata_shifted_s[8*i +: 8];
            end
        end
    end

    // Request/response FSM; the load result is captured at accept and held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            lat_cnt_r   <= 3'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        rsp_error_r <= error_s;
                        rsp_rdata_r <= req_write ? 32'h0000_0000 : load_data_s;
                        if (!req_write && (READ_LATENCY > 1)) begin
                            lat_cnt_r <= LAT_INIT;
                            state_r   <= WAIT;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (lat_cnt_r == 3'd1) begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_error_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_error_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the core's word-only data memory.
- Adds RISC-V sub-word loads/stores (byte/half/word, signed/unsigned), byte-lane write masking and misalign/range/illegal-op error reporting.
- Uses a valid/ready request-response handshake with configurable read latency.
- Sits between the execute/memory stage and the data RAM; one transaction outstanding at a time.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- READ_LATENCY, 1, cycles from request accept to read response; legal range 1..4.
- ADDR_WIDTH, 32, width of the byte address port.

Ports:
- clock  in  1  system clock. One clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_address  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_error  out  1  request faulted.

Behaviour:
- **Reset values:** req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE. RAM contents are not cleared by reset_n; they initialise to zero at time 0 only.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, capture the request; go to WAIT if it is a load with READ_LATENCY>1, else go to RESP.
  - WAIT: counter runs from READ_LATENCY-1 down to 1; go to RESP when it expires.
  - RESP: rsp_valid=1, outputs held stable; on rsp_ready go to IDLE.
- **Handshake:** req_ready=0 in WAIT and RESP. There is no same-cycle turnaround from RESP to a new accept; the next accept happens at the earliest one cycle after the rsp handshake.
- **Latency:**
  - Load: rsp_valid asserts READ_LATENCY cycles after the accept edge.
  - Store: rsp_valid asserts 1 cycle after the accept edge.
- **Word index:** address[log2(DEPTH_WORDS)+1:2]. Lane = address[1:0].
- **Range error:** any address bit at or above log2(DEPTH_WORDS)+2 set.
- **funct3 decode:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code raises an illegal-op error.
- **Misalign error:** halfword with address[0]=1; word with address[1:0]≠0.
- **Error priority:** illegal > misalign > range. All three produce rsp_error=1 and rsp_rdata=0. A faulting store writes nothing.
- **Stores:** committed to RAM on the accept edge, using a byte-enable mask.
  - SB: lane byte = wdata[7:0].
  - SH: lanes {a1,a1+1} = wdata[15:0].
  - SW: all four lanes.
  - Unmasked bytes are preserved.
- **Loads:** the RAM word is read on the accept edge, then delayed through the READ_LATENCY pipeline.
  - Lane selection and extension are applied at capture.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **Ordering:** with a single outstanding request, a load after a store to the same word always returns the new data.
- **Reset mid-operation:** asserting reset_n low in WAIT or RESP drops the pending response. A store already committed remains in RAM.
- **Backpressure:** rsp_ready held low keeps RESP indefinitely with stable outputs.

Decomposition:
- **Shared package lsu_pkg:**
  - funct3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum: IDLE/WAIT/RESP.
- **Sub-module lsu_align:** purely combinational. Produces the byte-enable mask, shifted write data, load extraction/extension and error flags. It keeps the FSM and RAM logic in the top module clean.

Test Plan:
- **SW then LW:** SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_error=0; the load response arrives exactly READ_LATENCY cycles after accept (check with READ_LATENCY=1 and 3).
- **Sub-word loads:** after the SW above, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- **Byte-masked store:** SB addr 0x11 data 0x00000055 over 0xDEADBEEF, then LW 0x10 → 0xDEAD55EF.
- **Errors:**
  - LW 0x12 → rsp_error=1, rdata=0.
  - SH 0x21 → error, and a subsequent LW 0x20 still returns its prior value.
  - funct3=011 → error.
  - With DEPTH_WORDS=256, address 0x400 → range error.
- **Backpressure:** hold rsp_ready=0 for 5 cycles → rsp_valid stays 1 with stable rsp_rdata, req_ready=0, and a second req_valid is not accepted; release → accept occurs one cycle after the handshake.
- **Reset mid-operation:** pull reset_n low in WAIT (READ_LATENCY=4) → rsp_valid=0 and req_ready=1 immediately; a store accepted before the reset is visible to a later LW.
